// File: rtl/wb_stream_reader_ctrl.sv
// Wishbone burst-write DMA master: drains a FWFT stream FIFO into a linear
// memory buffer using incrementing bursts of at most burst_size words.
module wb_stream_reader_ctrl #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 9
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [WB_AW-1:0]   buf_size,
  input  logic [WB_AW-1:0]   burst_size,
  output logic               busy,
  output logic [WB_DW-1:0]   tx_cnt,
  output logic               err,
  input  logic [WB_DW-1:0]   fifo_d,
  input  logic [FIFO_AW:0]   fifo_cnt,
  output logic               fifo_rd,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WB_AW-1:0] adr_q, adr_d;
  logic [WB_AW-1:0] buf_size_q, buf_size_d;
  logic [WB_AW-1:0] burst_q, burst_d;
  logic [WB_AW-1:0] beat_q, beat_d;
  logic [WB_DW-1:0] tx_cnt_q, tx_cnt_d;
  logic             err_q, err_d;

  logic [WB_AW-1:0] remaining;
  logic [WB_AW-1:0] blen;
  logic [WB_AW-1:0] fifo_avail;

  assign remaining  = buf_size_q - WB_AW'(tx_cnt_q);
  assign blen       = (burst_q < remaining) ? burst_q : remaining;
  assign fifo_avail = WB_AW'(fifo_cnt);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= ST_IDLE;
      adr_q      <= '0;
      buf_size_q <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      tx_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      buf_size_q <= buf_size_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      tx_cnt_q   <= tx_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    buf_size_d = buf_size_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    tx_cnt_d   = tx_cnt_q;
    err_d      = 1'b0;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_cti_o  = 3'b000;
    fifo_rd    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && (buf_size != '0)) begin
          adr_d      = start_adr & ~WB_AW'(3);
          buf_size_d = buf_size;
          // A zero burst length would never make progress; run single beats instead.
          burst_d    = (burst_size == '0) ? WB_AW'(1) : burst_size;
          tx_cnt_d   = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fifo_avail >= blen) begin
          beat_d  = blen;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_cti_o = (beat_q == WB_AW'(1)) ? 3'b111 : 3'b010;
        // Error takes priority over a simultaneous ack: that beat is neither counted nor popped.
        if (wbm_err_i) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (wbm_ack_i) begin
          fifo_rd  = 1'b1;
          tx_cnt_d = tx_cnt_q + WB_DW'(1);
          adr_d    = adr_q + WB_AW'(4);
          beat_d   = beat_q - WB_AW'(1);
          if (beat_q == WB_AW'(1)) begin
            state_d = (WB_AW'(tx_cnt_d) == buf_size_q) ? ST_IDLE : ST_WAIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign tx_cnt    = tx_cnt_q;
  assign err       = err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = fifo_d;
  assign wbm_sel_o = '1;
  assign wbm_bte_o = 2'b00;

endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// Self-checking bench for wb_stream_reader_ctrl: FIFO and Wishbone slave models
// plus a burst-plan reference model built from the transfer parameters.
module tb_wb_stream_reader_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] start_adr, buf_size, burst_size;
  logic        busy, err, fifo_rd;
  logic [31:0] tx_cnt, fifo_d, wbm_adr_o, wbm_dat_o;
  logic [9:0]  fifo_cnt;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        ack, err_i;

  int checks;
  int failures;

  // FIFO model: words written by the stimulus, popped on fifo_rd
  logic [31:0] mem [0:1023];
  int wr_ptr, rd_ptr, cap, avail;
  assign avail    = wr_ptr - rd_ptr;
  assign fifo_cnt = 10'((avail > cap) ? cap : avail);
  assign fifo_d   = mem[rd_ptr % 1024];

  // slave configuration
  int ws;
  int err_beat;

  // monitor state
  int beat_idx, stab_viol, rd_viol, proto_viol, wcnt;
  bit have_prev;
  logic [31:0] prev_adr, prev_dat;
  logic [2:0]  prev_cti;
  logic [31:0] obs_adr[$];
  logic [31:0] obs_dat[$];
  logic [2:0]  obs_cti[$];

  // reference plan
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  logic [2:0]  exp_cti[$];
  int obs0, pop0, sv0, rv0, pv0;

  wb_stream_reader_ctrl #(.WB_AW(32), .WB_DW(32), .FIFO_AW(9)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .enable(enable),
    .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
    .busy(busy), .tx_cnt(tx_cnt), .err(err),
    .fifo_d(fifo_d), .fifo_cnt(fifo_cnt), .fifo_rd(fifo_rd),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_ack_i(ack), .wbm_err_i(err_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (fifo_rd === 1'b1) rd_ptr <= rd_ptr + 1;
  end

  // Wishbone slave: decides ack/err half a cycle before the sampling edge
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      ack = 1'b0; err_i = 1'b0; wcnt = 0; have_prev = 1'b0;
    end else if (wbm_cyc_o === 1'b1) begin
      if (wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1 || wbm_sel_o !== 4'hF || wbm_bte_o !== 2'b00)
        proto_viol++;
      if (have_prev && (wbm_adr_o !== prev_adr || wbm_dat_o !== prev_dat || wbm_cti_o !== prev_cti))
        stab_viol++;
      if (wcnt < ws) begin
        ack = 1'b0; err_i = 1'b0; wcnt++;
        have_prev = 1'b1;
        prev_adr = wbm_adr_o; prev_dat = wbm_dat_o; prev_cti = wbm_cti_o;
      end else begin
        wcnt = 0; have_prev = 1'b0;
        ack = 1'b1;
        err_i = (beat_idx == err_beat);
        obs_adr.push_back(wbm_adr_o);
        obs_dat.push_back(wbm_dat_o);
        obs_cti.push_back(wbm_cti_o);
        beat_idx++;
      end
    end else begin
      ack = 1'b0; err_i = 1'b0; wcnt = 0; have_prev = 1'b0;
      if (wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 || wbm_bte_o !== 2'b00) proto_viol++;
    end
    #1;
    if (fifo_rd !== (ack & ~err_i & wbm_stb_o)) rd_viol++;
  end

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 1024] = $urandom;
      wr_ptr++;
    end
  endtask

  task automatic pulse_enable(input logic [31:0] s, input logic [31:0] n, input logic [31:0] b);
    @(negedge clk); #2;
    start_adr = s; buf_size = n; burst_size = b; enable = 1'b1;
    @(negedge clk); #2;
    enable = 1'b0;
  endtask

  // Expected beat list: bursts of min(burst, remaining), last beat of each burst is 111.
  task automatic start_xfer(input string nm, input logic [31:0] s, input int n, input int b);
    int done, bl, eb;
    exp_adr.delete(); exp_dat.delete(); exp_cti.delete();
    eb = (b == 0) ? 1 : b;
    done = 0;
    while (done < n) begin
      bl = ((n - done) < eb) ? (n - done) : eb;
      for (int j = 0; j < bl; j++) begin
        exp_adr.push_back((s & 32'hFFFF_FFFC) + 32'(4 * (done + j)));
        exp_dat.push_back(mem[(rd_ptr + done + j) % 1024]);
        exp_cti.push_back((j == bl - 1) ? 3'b111 : 3'b010);
      end
      done += bl;
    end
    obs0 = obs_adr.size(); pop0 = rd_ptr;
    sv0 = stab_viol; rv0 = rd_viol; pv0 = proto_viol;
    pulse_enable(s, 32'(n), 32'(b));
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL %s busy_after_enable: got %b expected 1", nm, busy);
    end
  endtask

  task automatic finish_xfer(input string nm, input int n_words, input int n_beats, input bit exp_err);
    int errs, got, lim;
    bit done;
    errs = 0; done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk); #2;
      if (err === 1'b1) begin
        errs++;
        checks++;
        if (wbm_cyc_o !== 1'b0 || busy !== 1'b0) begin
          failures++; $display("FAIL %s err_pulse_state: cyc=%b busy=%b expected 0 0", nm, wbm_cyc_o, busy);
        end
      end
      if (busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL %s timeout: busy still %b after 3000 cycles expected 0", nm, busy); end
    checks++;
    if (errs != (exp_err ? 1 : 0)) begin
      failures++; $display("FAIL %s err_pulses: got %0d expected %0d", nm, errs, exp_err ? 1 : 0);
    end
    @(negedge clk); #2;
    checks++;
    if (err !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      failures++; $display("FAIL %s idle_after: err=%b cyc=%b expected 0 0", nm, err, wbm_cyc_o);
    end
    checks++;
    if (tx_cnt !== 32'(n_words)) begin
      failures++; $display("FAIL %s tx_cnt: got %0d expected %0d", nm, tx_cnt, n_words);
    end
    checks++;
    if (rd_ptr - pop0 != n_words) begin
      failures++; $display("FAIL %s pops: got %0d expected %0d", nm, rd_ptr - pop0, n_words);
    end
    got = obs_adr.size() - obs0;
    checks++;
    if (got != n_beats) begin
      failures++; $display("FAIL %s beat_count: got %0d expected %0d", nm, got, n_beats);
    end
    lim = (got < n_beats) ? got : n_beats;
    for (int i = 0; i < lim; i++) begin
      checks++;
      if (obs_adr[obs0+i] !== exp_adr[i] || obs_dat[obs0+i] !== exp_dat[i] || obs_cti[obs0+i] !== exp_cti[i]) begin
        failures++;
        $display("FAIL %s beat%0d: got adr=%h dat=%h cti=%b expected adr=%h dat=%h cti=%b", nm, i,
                 obs_adr[obs0+i], obs_dat[obs0+i], obs_cti[obs0+i], exp_adr[i], exp_dat[i], exp_cti[i]);
      end
    end
    checks++;
    if (stab_viol != sv0 || rd_viol != rv0 || proto_viol != pv0) begin
      failures++;
      $display("FAIL %s bus_rules: got stab=%0d rd=%0d proto=%0d violations expected 0", nm,
               stab_viol - sv0, rd_viol - rv0, proto_viol - pv0);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    checks++;
    if (busy !== 1'b0 || tx_cnt !== 32'd0 || err !== 1'b0 || fifo_rd !== 1'b0 || wbm_cyc_o !== 1'b0 ||
        wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 || wbm_cti_o !== 3'b000 || wbm_adr_o !== 32'd0) begin
      failures++;
      $display("FAIL %s reset_outputs: got busy=%b tx=%0d err=%b rd=%b cyc=%b stb=%b we=%b cti=%b adr=%h expected all 0",
               nm, busy, tx_cnt, err, fifo_rd, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o, wbm_adr_o);
    end
  endtask

  task automatic test_reset;
    @(negedge clk); #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_two_bursts;
    ws = 0;
    push_words(8);
    start_xfer("two_bursts", 32'h1000, 8, 4);
    finish_xfer("two_bursts", 8, 8, 1'b0);
    $display("test_two_bursts: start=1000 size=8 burst=4");
  endtask

  task automatic test_tail_burst;
    push_words(5);
    start_xfer("tail_burst", 32'h2000, 5, 4);
    finish_xfer("tail_burst", 5, 5, 1'b0);
    $display("test_tail_burst: start=2000 size=5 burst=4");
  endtask

  task automatic test_wait_gate;
    push_words(4);
    cap = 2;
    start_xfer("wait_gate", 32'h2400, 4, 4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #2;
      checks++;
      if (wbm_cyc_o !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL wait_gate hold%0d: cyc=%b busy=%b expected 0 1", i, wbm_cyc_o, busy);
      end
    end
    cap = 1000;
    @(negedge clk); #2;
    checks++;
    if (wbm_cyc_o !== 1'b1) begin
      failures++; $display("FAIL wait_gate start: cyc=%b expected 1", wbm_cyc_o);
    end
    finish_xfer("wait_gate", 4, 4, 1'b0);
    $display("test_wait_gate: fifo_cnt held at 2 then raised");
  endtask

  task automatic test_wait_states;
    ws = 3;
    push_words(8);
    start_xfer("wait_states", 32'h8000, 8, 4);
    finish_xfer("wait_states", 8, 8, 1'b0);
    ws = 0;
    $display("test_wait_states: 3 wait states per beat");
  endtask

  task automatic test_error;
    push_words(8);
    err_beat = beat_idx + 2;
    start_xfer("error", 32'h9000, 8, 4);
    finish_xfer("error", 2, 3, 1'b1);
    err_beat = -1;
    $display("test_error: err on beat 3");
  endtask

  task automatic test_reset_and_ignored;
    int p;
    bit seen;
    ws = 1;
    push_words(8);
    start_xfer("mid_reset", 32'h3000, 8, 8);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk); #2;
      if (wbm_cyc_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL mid_reset burst_start: cyc=%b expected 1", wbm_cyc_o); end
    @(negedge clk); @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    p = rd_ptr;
    @(negedge clk); @(negedge clk); #2;
    checks++;
    if (rd_ptr != p) begin failures++; $display("FAIL mid_reset pops_in_reset: got %0d expected 0", rd_ptr - p); end
    rst_n = 1'b1;
    ws = 0;
    // transfer parked in WAIT, then a second enable that must be ignored
    push_words(3);
    cap = 0;
    start_xfer("busy_enable", 32'h4000, 3, 2);
    pulse_enable(32'h5000, 32'd6, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      checks++;
      if (wbm_cyc_o !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL busy_enable parked%0d: cyc=%b busy=%b expected 0 1", i, wbm_cyc_o, busy);
      end
    end
    cap = 1000;
    finish_xfer("busy_enable", 3, 3, 1'b0);
    p = rd_ptr;
    pulse_enable(32'h6000, 32'd0, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      checks++;
      if (busy !== 1'b0 || wbm_cyc_o !== 1'b0 || tx_cnt !== 32'd3 || rd_ptr != p) begin
        failures++;
        $display("FAIL zero_size%0d: busy=%b cyc=%b tx=%0d pops=%0d expected 0 0 3 0", i, busy, wbm_cyc_o, tx_cnt, rd_ptr - p);
      end
    end
    $display("test_reset_and_ignored: done");
  endtask

  task automatic test_random;
    int n, b;
    logic [31:0] s;
    for (int t = 0; t < 7; t++) begin
      n  = $urandom_range(12, 1);
      b  = $urandom_range(5, 0);
      ws = $urandom_range(2, 0);
      s  = $urandom;
      if (t == 0) begin s = 32'hFFFF_FFF6; n = 6; b = 4; end
      push_words(n);
      start_xfer("random", s, n, b);
      finish_xfer("random", n, n, 1'b0);
      $display("test_random: start=%h size=%0d burst=%0d ws=%0d", s, n, b, ws);
    end
    ws = 0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; enable = 1'b0;
    start_adr = '0; buf_size = '0; burst_size = '0;
    wr_ptr = 0; rd_ptr = 0; cap = 1000;
    ws = 0; err_beat = -1;
    beat_idx = 0; stab_viol = 0; rd_viol = 0; proto_viol = 0;
    test_reset();
    test_two_bursts();
    test_tail_burst();
    test_wait_gate();
    test_wait_states();
    test_error();
    test_reset_and_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stream_reader_ctrl.md
Name: wb_stream_reader_ctrl

Overview:
Wishbone master DMA engine for the stream-to-memory direction. It drains a first-word-fall-through stream FIFO and writes the data into a circular-free linear buffer in memory using incrementing Wishbone bursts. It is driven by a companion configuration block that supplies enable, start_adr, buf_size and burst_size, and reads back busy and tx_cnt.

Parameters:
WB_AW, 32, Wishbone address width.
WB_DW, 32, Wishbone data width. Must be 32; the byte stride is fixed at 4.
FIFO_AW, 9, width of the FIFO fill-count input.

Ports:
wb_clk_i  in  1  system clock.
wb_rst_n_i  in  1  reset, asynchronous, active-low.
enable  in  1  single-cycle start pulse.
start_adr  in  WB_AW  byte address of buffer start; bits [1:0] are ignored.
buf_size  in  WB_AW  transfer length in 32-bit words.
burst_size  in  WB_AW  maximum burst length in words.
busy  out  1  transfer in progress.
tx_cnt  out  WB_DW  words written in the current or last transfer.
err  out  1  one-cycle pulse on a bus error abort.
fifo_d  in  WB_DW  FIFO head data (FWFT).
fifo_cnt  in  FIFO_AW+1  words available in the FIFO.
fifo_rd  out  1  pop the FIFO head.
wbm_adr_o  out  WB_AW  byte address.
wbm_dat_o  out  WB_DW  write data.
wbm_sel_o  out  WB_DW/8  byte selects; always all ones.
wbm_we_o  out  1  always 1 while wbm_cyc_o is high.
wbm_cyc_o  out  1  bus cycle.
wbm_stb_o  out  1  strobe.
wbm_cti_o  out  3  cycle type.
wbm_bte_o  out  2  burst type; always 2'b00 (linear).
wbm_ack_i  in  1  slave acknowledge.
wbm_err_i  in  1  slave error.

Behaviour:
- Reset (asynchronous, wb_rst_n_i low): state IDLE; busy=0, tx_cnt=0, err=0, fifo_rd=0, wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_cti_o=0, wbm_adr_o=0. Reset mid-burst drops cyc/stb immediately and does not pop the FIFO.
- IDLE:
  - enable=1 with buf_size!=0: latch start_adr, buf_size and burst_size; clear tx_cnt; set busy=1 on the next cycle; go to WAIT.
  - enable with buf_size=0 is ignored.
  - enable while busy is ignored.
- Burst length blen = min(burst_size, buf_size - tx_cnt). A latched burst_size of 0 is treated as 1.
- WAIT: when fifo_cnt >= blen, load the burst word counter with blen and go to BURST on the next cycle. Otherwise hold, with cyc=0.
- BURST:
  - Drive cyc=stb=we=1, wbm_adr_o = start_adr + 4*tx_cnt, wbm_dat_o = fifo_d.
  - wbm_cti_o is 3'b010 for every beat except the last, which is 3'b111. A burst of one word is a single beat with cti=3'b111.
  - Each beat with wbm_ack_i=1: fifo_rd=1 in the same cycle (combinational from ack & stb), tx_cnt+1, address +4.
  - On the last beat's ack: deassert cyc/stb in the next cycle.
    - If tx_cnt reaches buf_size: go to IDLE and drop busy at the same edge cyc falls.
    - Otherwise go to WAIT.
  - Wait states (stb high, ack low) hold address, data and cti unchanged.
- Error: wbm_err_i during BURST ends the cycle. The errored beat is not counted and not popped. Pulse err for one cycle; go to IDLE with busy=0; tx_cnt keeps the count of acked words. If err and ack are both high, err wins.
- tx_cnt is a WB_DW-bit counter that holds its value after completion until the next accepted enable.
- Address arithmetic wraps modulo 2^WB_AW, with no error.
- The block never pops the FIFO outside acknowledged beats.

Test Plan:
- start_adr=0x1000, buf_size=8, burst_size=4, FIFO preloaded with 8 words -> two bursts at 0x1000 and 0x1010, cti 010,010,010,111 each, 8 pops, tx_cnt=8, busy falls after the 8th ack.
- buf_size=5, burst_size=4 -> a burst of 4 then a single beat with cti=111 at start_adr+0x10; tx_cnt=5.
- fifo_cnt held at 2 with burst_size=4 -> stays in WAIT with cyc=0. Raising fifo_cnt to 4 -> the burst starts the cycle after.
- Slave inserts 3 wait states per beat -> address, data and cti are stable during waits; exactly one pop per ack.
- wbm_err_i on the 3rd beat of the first burst -> err pulses once, busy=0, tx_cnt=2, 2 pops, cyc low the next cycle.
- Reset asserted mid-burst, then an enable while busy, then an enable with buf_size=0 -> after reset all outputs are at their reset values; both later enables are ignored (busy stays at its current value, no bus activity).
